// File: rtl/grf_pkg.sv
// Shared constants and types for the multiport register file.
// Optional write-through forwarding is enabled by defining GRF_BYPASS_EN.
package grf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 2;

    localparam int unsigned ZERO_ADDR = 0;

    typedef logic [CNT_W_DEF:0] cnt_upd_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending-write counters, issue gating and busy lookup.
// GRF_BYPASS_EN lets same-cycle writes clear busy early.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_iss_en,
    input  logic [ADDR_W-1:0]        i_iss_addr,
    output logic                     o_iss_ready,
    input  logic                     i_wr0_en,
    input  logic [ADDR_W-1:0]        i_wr0_addr,
    input  logic                     i_wr1_en,
    input  logic [ADDR_W-1:0]        i_wr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]        o_rd_busy,
    output logic                     o_sb_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [CNT_W:0] upd_t;

    logic [CNT_W-1:0] r_cnt [DEPTH];
    logic             r_err;

    logic             w_wr0_v;
    logic             w_wr1_v;
    logic             w_iss_wr;
    logic             w_iss_acc;
    upd_t             w_sum [DEPTH];
    upd_t             w_dec [DEPTH];
    logic [CNT_W-1:0] w_nxt [DEPTH];
    logic             w_uflow;

    assign w_wr0_v = i_wr0_en && (i_wr0_addr != ADDR_W'(ZERO_ADDR));
    assign w_wr1_v = i_wr1_en && (i_wr1_addr != ADDR_W'(ZERO_ADDR));

    // A full counter can still take an issue if a write frees a slot now.
    assign w_iss_wr = (w_wr0_v && (i_wr0_addr == i_iss_addr)) ||
                      (w_wr1_v && (i_wr1_addr == i_iss_addr));
    assign o_iss_ready = !((r_cnt[i_iss_addr] == CNT_MAX) && !w_iss_wr);
    assign w_iss_acc = i_iss_en && o_iss_ready &&
                       (i_iss_addr != ADDR_W'(ZERO_ADDR));

    always_comb begin
        w_uflow = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            w_sum[r] = {1'b0, r_cnt[r]} +
                       upd_t'(w_iss_acc && (i_iss_addr == ADDR_W'(r)));
            w_dec[r] = upd_t'(w_wr0_v && (i_wr0_addr == ADDR_W'(r))) +
                       upd_t'(w_wr1_v && (i_wr1_addr == ADDR_W'(r)));
            w_nxt[r] = '0;
            if (w_sum[r] < w_dec[r]) begin
                w_uflow = 1'b1;
            end else begin
                w_nxt[r] = CNT_W'(w_sum[r] - w_dec[r]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < DEPTH; r++) r_cnt[r] <= '0;
            r_err <= 1'b0;
        end else if (i_flush) begin
            for (int r = 0; r < DEPTH; r++) r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) r_cnt[r] <= w_nxt[r];
            if (w_uflow) r_err <= 1'b1;
        end
    end

    assign o_sb_err = r_err;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = i_rd_addr[k*ADDR_W +: ADDR_W];
`ifdef GRF_BYPASS_EN
        upd_t w_dk;
        assign w_dk = upd_t'(w_wr0_v && (i_wr0_addr == w_ra)) +
                      upd_t'(w_wr1_v && (i_wr1_addr == w_ra));
        assign o_rd_busy[k] = {1'b0, r_cnt[w_ra]} > w_dk;
`else
        assign o_rd_busy[k] = r_cnt[w_ra] != '0;
`endif
    end

endmodule

// File: rtl/grf_multiport.sv
// Multi-read, dual-write register file with pending-write scoreboard.
// Define GRF_BYPASS_EN for same-cycle write-through forwarding.
module grf_multiport
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic                     i_wr0_en,
    input  logic [ADDR_W-1:0]        i_wr0_addr,
    input  logic [DATA_W-1:0]        i_wr0_data,
    input  logic                     i_wr1_en,
    input  logic [ADDR_W-1:0]        i_wr1_addr,
    input  logic [DATA_W-1:0]        i_wr1_data,
    input  logic                     i_iss_en,
    input  logic [ADDR_W-1:0]        i_iss_addr,
    output logic                     o_iss_ready,
    input  logic                     i_flush,
    output logic                     o_sb_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              w_wr0_v;
    logic              w_wr1_v;

    assign w_wr0_v = i_wr0_en && (i_wr0_addr != ADDR_W'(ZERO_ADDR));
    assign w_wr1_v = i_wr1_en && (i_wr1_addr != ADDR_W'(ZERO_ADDR));

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < DEPTH; r++) r_regs[r] <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (w_wr1_v && (i_wr1_addr == ADDR_W'(r))) begin
                    r_regs[r] <= i_wr1_data;
                end else if (w_wr0_v && (i_wr0_addr == ADDR_W'(r))) begin
                    r_regs[r] <= i_wr0_data;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;
        assign w_ra = i_rd_addr[k*ADDR_W +: ADDR_W];
`ifdef GRF_BYPASS_EN
        assign w_rd = (w_wr1_v && (i_wr1_addr == w_ra)) ? i_wr1_data :
                      (w_wr0_v && (i_wr0_addr == w_ra)) ? i_wr0_data :
                      r_regs[w_ra];
`else
        assign w_rd = r_regs[w_ra];
`endif
        assign o_rd_data[k*DATA_W +: DATA_W] = w_rd;
    end

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .CNT_W  (CNT_W)
    ) u_sb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_iss_en    (i_iss_en),
        .i_iss_addr  (i_iss_addr),
        .o_iss_ready (o_iss_ready),
        .i_wr0_en    (i_wr0_en),
        .i_wr0_addr  (i_wr0_addr),
        .i_wr1_en    (i_wr1_en),
        .i_wr1_addr  (i_wr1_addr),
        .i_rd_addr   (i_rd_addr),
        .o_rd_busy   (o_rd_busy),
        .o_sb_err    (o_sb_err)
    );

endmodule

// File: tb/tb_grf_multiport.sv
// Directed scoreboard bench for grf_multiport.
// Expectations are queued by stimulus and checked on the falling edge.
module tb_grf_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int CW = 2;

`ifdef GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr0_en;
    logic [AW-1:0]    wr0_addr;
    logic [DW-1:0]    wr0_data;
    logic             wr1_en;
    logic [AW-1:0]    wr1_addr;
    logic [DW-1:0]    wr1_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             iss_ready;
    logic             flush;
    logic             sb_err;

    grf_multiport #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .CNT_W  (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_busy   (rd_busy),
        .i_wr0_en    (wr0_en),
        .i_wr0_addr  (wr0_addr),
        .i_wr0_data  (wr0_data),
        .i_wr1_en    (wr1_en),
        .i_wr1_addr  (wr1_addr),
        .i_wr1_data  (wr1_data),
        .i_iss_en    (iss_en),
        .i_iss_addr  (iss_addr),
        .o_iss_ready (iss_ready),
        .i_flush     (flush),
        .o_sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    // sel: 0/1 rd_data port, 2/3 rd_busy port, 4 iss_ready, 5 sb_err
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        exp_q[$];
    chk_t        mc;
    logic [31:0] act;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0:       return rd_data[0 +: DW];
            1:       return rd_data[DW +: DW];
            2:       return {31'b0, rd_busy[0]};
            3:       return {31'b0, rd_busy[1]};
            4:       return {31'b0, iss_ready};
            default: return {31'b0, sb_err};
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mc = exp_q.pop_front();
            act = observe(mc.sel);
            checks++;
            if (act !== mc.exp) begin
                errors++;
                $display("FAIL %s got %h want %h", mc.name, act, mc.exp);
            end
        end
    end

    task automatic expect_v(input string n, input int sel, input logic [31:0] v);
        chk_t c;
        c.name = n;
        c.sel  = sel;
        c.exp  = v;
        exp_q.push_back(c);
    endtask

    task automatic idle();
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        iss_en   = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        iss_en = 1'b1; iss_addr = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        wr0_addr = '0; wr0_data = '0;
        wr1_addr = '0; wr1_data = '0;
        iss_addr = '0;
        set_rd(5, 7);

        // Activity during reset must not leak into the array
        for (int i = 0; i < 3; i++) begin
            wr0(AW'($urandom_range(1, 31)), $urandom);
            wr1(5, $urandom);
            iss(7);
            expect_v("rst_rd5", 0, 32'h0);
            expect_v("rst_rd7", 1, 32'h0);
            expect_v("rst_busy5", 2, 32'h0);
            expect_v("rst_busy7", 3, 32'h0);
            expect_v("rst_sberr", 5, 32'h0);
            step();
        end
        expect_v("rst_issrdy", 4, 32'h1);
        rst_n = 1'b1;
        step();

        iss(5);
        expect_v("iss5_rdy", 4, 32'h1);
        step();
        wr0(5, 32'h1234_5678);
        expect_v("wr5_same_data", 0, BYP ? 32'h1234_5678 : 32'h0);
        expect_v("wr5_same_busy", 2, BYP ? 32'h0 : 32'h1);
        step();
        expect_v("wr5_next_data", 0, 32'h1234_5678);
        expect_v("wr5_next_busy", 2, 32'h0);
        step();

        iss(7);
        step();
        iss(7);
        step();
        expect_v("r7_busy_pre", 3, 32'h1);
        wr0(7, 32'hAAAA_AAAA);
        wr1(7, 32'h5555_5555);
        expect_v("r7_same_data", 1, BYP ? 32'h5555_5555 : 32'h0);
        expect_v("r7_same_busy", 3, BYP ? 32'h0 : 32'h1);
        step();
        expect_v("r7_next_data", 1, 32'h5555_5555);
        expect_v("r7_next_busy", 3, 32'h0);
        expect_v("r7_sberr", 5, 32'h0);
        step();

        set_rd(0, 7);
        wr0(0, 32'hFFFF_FFFF);
        wr1(0, 32'hFFFF_FFFF);
        iss(0);
        expect_v("r0_same_data", 0, 32'h0);
        expect_v("r0_same_busy", 2, 32'h0);
        expect_v("r0_issrdy", 4, 32'h1);
        step();
        expect_v("r0_next_data", 0, 32'h0);
        expect_v("r0_next_busy", 2, 32'h0);
        expect_v("r0_sberr", 5, 32'h0);
        step();

        set_rd(3, 7);
        for (int i = 0; i < 3; i++) begin
            iss(3);
            expect_v("r3_iss_rdy", 4, 32'h1);
            step();
        end
        expect_v("r3_busy_full", 2, 32'h1);
        iss(3);
        expect_v("r3_full_rdy", 4, 32'h0);
        step();
        iss(3);
        wr0(3, 32'h33);
        expect_v("r3_full_wr_rdy", 4, 32'h1);
        step();
        // Drain three writes; busy must persist until the third
        for (int i = 0; i < 3; i++) begin
            wr0(3, 32'h33);
            step();
            expect_v("r3_drain_busy", 2, (i < 2) ? 32'h1 : 32'h0);
            step();
        end
        expect_v("r3_drain_sberr", 5, 32'h0);
        expect_v("r3_drain_data", 0, 32'h33);
        step();

        set_rd(9, 7);
        iss(9);
        step();
        iss(9);
        step();
        expect_v("r9_busy", 2, 32'h1);
        flush = 1'b1;
        iss(9);
        step();
        expect_v("r9_flushed_busy", 2, 32'h0);
        expect_v("r9_flushed_rdy", 4, 32'h1);
        step();
        wr0(9, 32'h99);
        step();
        expect_v("r9_sberr_set", 5, 32'h1);
        step();
        step();
        expect_v("r9_sberr_sticky", 5, 32'h1);
        expect_v("r9_data", 0, 32'h99);
        step();

        set_rd(4, 5);
        for (int i = 0; i < 3; i++) begin
            iss(4);
            step();
        end
        wr0(4, 32'h10);
        step();
        expect_v("r4_data", 0, 32'h10);
        expect_v("r4_busy", 2, 32'h1);
        step();
        // Drop reset between edges; checked before the next rising edge
        rst_n = 1'b0;
        expect_v("arst_r4_data", 0, 32'h0);
        expect_v("arst_r4_busy", 2, 32'h0);
        expect_v("arst_r5_data", 1, 32'h0);
        expect_v("arst_sberr", 5, 32'h0);
        expect_v("arst_issrdy", 4, 32'h1);
        step();
        rst_n = 1'b1;
        step();
        step();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_multiport.md
# grf_multiport

Parametrised general register file for the pipelined CPU: configurable data width, depth and number of read ports, with two write ports and a per-register pending-write scoreboard. The scoreboard lets the decode stage stall on RAW hazards. It sits between decode (reads, issue) and the M/W stages (writes) and replaces the fixed 32×32, 2-read/1-write file.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- CNT_W, 2, width of each register's pending-write counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all registers, counters and `sb_err`
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy  out  NUM_RD  read register still has an outstanding write
- wr0_en / wr0_addr / wr0_data  in  1 / ADDR_W / DATA_W  write port 0, the older W-stage result
- wr1_en / wr1_addr / wr1_data  in  1 / ADDR_W / DATA_W  write port 1, the younger early-result port
- iss_en  in  1  issue request: instruction will write `iss_addr`
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- iss_ready  out  1  issue can be accepted this cycle
- flush  in  1  synchronous clear of all pending counters (pipeline flush)
- sb_err  out  1  sticky: a write arrived for a register whose counter was 0

## Operation
- Register 0 reads 0 always. Writes, issues and counter updates to address 0 are ignored. rd_busy for address 0 is 0.
- Write: an enabled port writes `regs[addr] <= data` at the edge.
  - Both ports enabled with the same address: port 1 data wins.
  - The counter for that address still decrements by 2.
- Counter update per register r each edge: `cnt[r] <= cnt[r] + inc - dec`.
  - inc = 1 when issue is accepted (`iss_en && iss_ready`) and `iss_addr == r`.
  - dec = number of enabled write ports addressing r (0..2).
  - Computed in CNT_W+1 bits.
  - A result below 0 clamps to 0 and sets `sb_err`.
- iss_ready = 0 only when `cnt[iss_addr]` is at maximum (2**CNT_W−1) and no write to `iss_addr` occurs this cycle. Otherwise iss_ready = 1. It is combinational.
- A request with iss_en=1 and iss_ready=0 is not accepted and has no effect. The requester holds iss_addr and retries.
- flush: all counters go to 0 at the edge. Same-cycle issue and write decrements are discarded. Register writes still occur. sb_err is unaffected.
- Reset mid-operation: every register and counter reads 0 immediately (asynchronous). sb_err = 0.
- rd_busy[k] = `cnt[rd_addr_k] != 0`, computed from registered counters, except as modified by GRF_BYPASS_EN.

## Timing
- Reads are combinational from address to rd_data and rd_busy, with zero cycles of latency.
- A write becomes visible in the array one cycle after the edge, or in the same cycle through bypass (see Configuration).
- Issue takes effect on rd_busy from the next cycle.
- Reset values: rd_data = 0 for all addresses, rd_busy = 0, iss_ready = 1, sb_err = 0.

## Configuration
- GRF_BYPASS_EN defined: write-through forwarding.
  - A read whose address matches an enabled write port (address ≠ 0) returns that port's wr_data in the same cycle. Port 1 takes priority over port 0, which takes priority over the array.
  - rd_busy[k] also drops to 0 in that cycle if the matching writes bring the counter to 0.
- GRF_BYPASS_EN undefined: reads return array contents only. A same-cycle write is visible next cycle. rd_busy uses registered counters only.

## Structure
- grf_pkg holds:
  - Default parameter constants: DATA_W_DEF, ADDR_W_DEF, CNT_W_DEF.
  - The zero-register address constant.
  - A typedef for counter-update width (CNT_W+1).
- Sub-module grf_scoreboard holds the counter array, iss_ready, flush, sb_err and per-port busy lookup. grf_multiport holds the data array, write arbitration and bypass muxes.

## Test plan
- Reset low with random writes applied → all rd_data = 0, rd_busy = 0, sb_err = 0. After reset high, write r5=0x1234_5678 on port 0 → read r5 next cycle returns 0x1234_5678.
- Same-cycle write of r7: port 0 = 0xAAAA_AAAA, port 1 = 0x5555_5555 → r7 = 0x5555_5555. With GRF_BYPASS_EN, a same-cycle read of r7 = 0x5555_5555. Without it, the same-cycle read returns the old value.
- Write r0=0xFFFF_FFFF on both ports and issue r0 → r0 reads 0, rd_busy = 0, sb_err = 0.
- Issue r3 three times (CNT_W=2) → rd_busy = 1 and iss_ready = 1. A fourth issue → iss_ready = 0 and the counter stays 3. A fourth issue with a wr0 write to r3 in the same cycle → accepted, counter stays 3.
- Issue r9 twice, then flush → rd_busy(r9) = 0 next cycle. A following wr0 to r9 → sb_err = 1 and it stays 1 until reset.
- Assert reset while r4 counter = 2 and r4 = 0x10 → r4 reads 0 and rd_busy = 0 immediately, without waiting for a clock edge.
